// File: rtl/insight_trace_collector_pkg.sv
`default_nettype none
// ==================================================================
// insight_trace_pkg : shared trace record type and helper functions
// Rev 1.0
// ==================================================================
package insight_trace_pkg;

    localparam int XLEN_MAX = 64;

    // Fields are sized for the widest XLEN; narrower configurations zero-extend.
    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [31:0]         insn;
        logic                rd_we;
        logic [4:0]          rd_addr;
        logic [XLEN_MAX-1:0] rd_wdata;
        logic                trap;
        logic                intr;
    } trace_rec_t;

    function automatic int hart_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] drop_sat_inc(input logic [31:0] v, input int w);
        logic [31:0] lim;
        lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v == lim) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/insight_trace_collector_if.sv
`default_nettype none
// ==================================================================
// insight_trace_if : retirement capture bus plus merged trace stream
// Rev 1.0
// ==================================================================
interface insight_trace_if #(
    parameter int N_HARTS = 2,
    parameter int XLEN    = 32,
    parameter int DROP_W  = 16
);
    import insight_trace_pkg::*;

    localparam int HART_W = hart_w(N_HARTS);

    logic                      enable;
    logic [N_HARTS-1:0]        ret_valid;
    logic [N_HARTS*XLEN-1:0]   ret_pc;
    logic [N_HARTS*32-1:0]     ret_insn;
    logic [N_HARTS-1:0]        ret_rd_we;
    logic [N_HARTS*5-1:0]      ret_rd_addr;
    logic [N_HARTS*XLEN-1:0]   ret_rd_wdata;
    logic [N_HARTS-1:0]        ret_trap;
    logic [N_HARTS-1:0]        ret_intr;
    logic                      out_valid;
    logic                      out_ready;
    logic [HART_W-1:0]         out_hart;
    trace_rec_t                out_rec;
    logic [31:0]               out_seq;
    logic [N_HARTS*DROP_W-1:0] drop_cnt;
    logic [N_HARTS-1:0]        ovf_sticky;
    logic                      clr_stats;

    modport master (
        output enable, ret_valid, ret_pc, ret_insn, ret_rd_we, ret_rd_addr,
               ret_rd_wdata, ret_trap, ret_intr, out_ready, clr_stats,
        input  out_valid, out_hart, out_rec, out_seq, drop_cnt, ovf_sticky
    );

    modport slave (
        input  enable, ret_valid, ret_pc, ret_insn, ret_rd_we, ret_rd_addr,
               ret_rd_wdata, ret_trap, ret_intr, out_ready, clr_stats,
        output out_valid, out_hart, out_rec, out_seq, drop_cnt, ovf_sticky
    );

endinterface
`default_nettype wire

// File: rtl/insight_trace_collector_fifo.sv
`default_nettype none
// ==================================================================
// insight_trace_fifo : single-hart synchronous FIFO of trace records
// Rev 1.0
// ==================================================================
module insight_trace_fifo
    import insight_trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push_i,
    input  trace_rec_t din_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output trace_rec_t head_o
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

    trace_rec_t  mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic        do_pop;

    assign empty_o = (wr_q == rd_q);
    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_o  = mem_q[rd_q[AW-1:0]];
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d = push_i ? wr_q + PTR_ONE : wr_q;
        rd_d = do_pop ? rd_q + PTR_ONE : rd_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_q[AW-1:0]] <= din_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/insight_trace_collector.sv
`default_nettype none
// ==================================================================
// insight_trace_collector : per-hart retirement FIFOs merged round-robin
// Rev 1.0
// ==================================================================
module insight_trace_collector
    import insight_trace_pkg::*;
#(
    parameter int N_HARTS = 2,
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int DROP_W  = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    insight_trace_if.slave bus
);
    localparam int HART_W = hart_w(N_HARTS);

    logic [N_HARTS-1:0] empty, full, push, pop, drop;
    trace_rec_t         head [N_HARTS];
    logic [HART_W-1:0]  rr_q, rr_d, hold_hart_q, scan, grant;
    logic               hold_q, out_valid, handshake;
    logic [31:0]        seq_q, seq_d;
    logic [DROP_W-1:0]  drop_cnt_q [N_HARTS];
    logic [DROP_W-1:0]  drop_cnt_d [N_HARTS];
    logic [N_HARTS-1:0] ovf_q, ovf_d;

    generate
        for (genvar h = 0; h < N_HARTS; h++) begin : g_hart
            trace_rec_t rec;
            always_comb begin
                rec                    = '0;
                rec.pc[XLEN-1:0]       = bus.ret_pc[h*XLEN +: XLEN];
                rec.insn               = bus.ret_insn[h*32 +: 32];
                rec.rd_we              = bus.ret_rd_we[h];
                rec.rd_addr            = bus.ret_rd_addr[h*5 +: 5];
                rec.rd_wdata[XLEN-1:0] = bus.ret_rd_wdata[h*XLEN +: XLEN];
                rec.trap               = bus.ret_trap[h];
                rec.intr               = bus.ret_intr[h];
            end
            // A pop of the same FIFO this cycle frees the slot the push needs.
            assign push[h] = bus.enable && bus.ret_valid[h] && (!full[h] || pop[h]);
            assign drop[h] = bus.enable && bus.ret_valid[h] && full[h] && !pop[h];
            assign pop[h]  = handshake && (grant == HART_W'(h));

            insight_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
                .clock   (clock),
                .reset_n (reset_n),
                .push_i  (push[h]),
                .din_i   (rec),
                .pop_i   (pop[h]),
                .full_o  (full[h]),
                .empty_o (empty[h]),
                .head_o  (head[h])
            );
        end
    endgenerate

    // Lowest non-empty hart >= rr_q wins; otherwise wrap to lowest non-empty.
    always_comb begin
        logic                found_hi;
        logic [HART_W-1:0]   hi, lo;
        found_hi = 1'b0;
        hi       = '0;
        lo       = '0;
        for (int h = N_HARTS - 1; h >= 0; h--) begin
            if (!empty[h]) begin
                lo = HART_W'(h);
                if (HART_W'(h) >= rr_q) begin
                    hi       = HART_W'(h);
                    found_hi = 1'b1;
                end
            end
        end
        scan = found_hi ? hi : lo;
    end

    assign out_valid = |(~empty);
    assign grant     = hold_q ? hold_hart_q : scan;
    assign handshake = out_valid && bus.out_ready;

    always_comb begin
        rr_d  = rr_q;
        seq_d = seq_q;
        if (handshake) begin
            rr_d  = (grant == HART_W'(N_HARTS - 1)) ? '0 : grant + HART_W'(1);
            seq_d = seq_q + 32'd1;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        for (int h = 0; h < N_HARTS; h++) begin
            drop_cnt_d[h] = drop_cnt_q[h];
            if (bus.clr_stats) begin
                drop_cnt_d[h] = '0;
                ovf_d[h]      = 1'b0;
            end else if (drop[h]) begin
                drop_cnt_d[h] = DROP_W'(drop_sat_inc(32'(drop_cnt_q[h]), DROP_W));
                ovf_d[h]      = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_q        <= '0;
            seq_q       <= '0;
            hold_q      <= 1'b0;
            hold_hart_q <= '0;
            ovf_q       <= '0;
            for (int h = 0; h < N_HARTS; h++) drop_cnt_q[h] <= '0;
        end else begin
            rr_q        <= rr_d;
            seq_q       <= seq_d;
            hold_q      <= out_valid && !bus.out_ready;
            hold_hart_q <= grant;
            ovf_q       <= ovf_d;
            for (int h = 0; h < N_HARTS; h++) drop_cnt_q[h] <= drop_cnt_d[h];
        end
    end

    always_comb begin
        bus.out_rec  = '0;
        bus.drop_cnt = '0;
        for (int h = 0; h < N_HARTS; h++) begin
            if (out_valid && (grant == HART_W'(h))) bus.out_rec = head[h];
            bus.drop_cnt[h*DROP_W +: DROP_W] = drop_cnt_q[h];
        end
    end

    assign bus.out_valid  = out_valid;
    assign bus.out_hart   = out_valid ? grant : '0;
    assign bus.out_seq    = seq_q;
    assign bus.ovf_sticky = ovf_q;

endmodule
`default_nettype wire

// File: doc/insight_trace_collector.md
Name: insight_trace_collector

Overview:
- Multi-hart retirement-trace collector for the Insight probe layer.
- Successor to the single-hart (hart 0) tile probe, parametrised in hart count, XLEN and buffer depth.
- Captures per-hart retirement packets (PC, instruction, GPR writeback, trap/CLIC-interrupt flags) into per-hart FIFOs.
- Merges the FIFOs round-robin onto one valid/ready stream consumed by the RISCV-DV trace writer/scoreboard; counts dropped packets per hart.

Parameters:
N_HARTS, 2, number of harts traced (1..8)
XLEN, 32, PC/data width (32 or 64)
DEPTH, 4, entries per hart FIFO; power of 2, >=2
DROP_W, 16, width of per-hart saturating drop counter

Ports:
clock  in  1  sole clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  capture enable; when 0 no pushes, drain continues
ret_valid  in  N_HARTS  per-hart retirement strobe, 1 packet/hart/cycle
ret_pc  in  N_HARTS*XLEN  retired PC
ret_insn  in  N_HARTS*32  retired instruction bits
ret_rd_we  in  N_HARTS  GPR write valid
ret_rd_addr  in  N_HARTS*5  GPR index
ret_rd_wdata  in  N_HARTS*XLEN  GPR write data
ret_trap  in  N_HARTS  retirement took exception
ret_intr  in  N_HARTS  retirement took CLIC interrupt
out_valid  out  1  record available
out_ready  in  1  consumer accepts
out_hart  out  $clog2(N_HARTS) min 1  source hart id
out_rec  out  packed trace_rec_t  pc/insn/rd_we/rd_addr/rd_wdata/trap/intr
out_seq  out  32  global sequence number of presented record
drop_cnt  out  N_HARTS*DROP_W  per-hart dropped-packet counts
ovf_sticky  out  N_HARTS  per-hart overflow seen
clr_stats  in  1  synchronous clear of drop_cnt and ovf_sticky

Behaviour:
- Reset (async assert, sync release): all FIFOs empty, out_valid=0, out_hart=0, out_rec=0, out_seq=0, drop_cnt=0, ovf_sticky=0, RR pointer=0.
- Push: ret_valid[h] && enable writes the packet into FIFO h at the clock edge. Earliest out_valid for that packet is the next cycle (latency 1).
- Full FIFO with no pop of h that cycle:
  - packet dropped;
  - drop_cnt[h] increments, saturating at all-ones;
  - ovf_sticky[h] set.
- Full FIFO with pop of h in the same cycle: push accepted, no drop.
- Arbiter: out_valid = any FIFO non-empty. Grant goes to the first non-empty hart at or after the RR pointer, with wrap-around.
- Handshake (out_valid && out_ready): pop the granted FIFO, RR pointer <- granted+1 mod N_HARTS, out_seq increments (wraps 2^32-1 -> 0).
- Hold rule: while out_valid && !out_ready, grant is locked. out_hart/out_rec/out_seq stay stable even if higher-priority harts become non-empty.
- out_rec and out_hart are driven from the FIFO head (no extra output register).
- Packets from one hart emerge in retirement order. No ordering is guaranteed between harts; out_seq gives merged order.
- clr_stats has priority over an increment in the same cycle: result is 0, not 1.
- enable=0: pushes ignored and not counted as drops; draining unaffected.
- N_HARTS=1: arbiter degenerates; out_hart=0.

Decomposition:
- Package insight_trace_pkg:
  - trace_rec_t packed struct, parametrised via localparams XLEN_MAX=64, sized fields;
  - HART_W function;
  - drop-counter saturate helper.
- Sub-module insight_trace_fifo: single-hart sync FIFO of trace_rec_t.
  - Ports: push/pop/full/empty/head.
  - Pointer width $clog2(DEPTH)+1, wrap-bit full detect.
  - Instantiated N_HARTS times by generate.

Test Plan:
- Single push hart1 pc=0x8000_0004, out_ready=1 -> cycle+1 out_valid=1, out_hart=1, out_rec.pc=0x8000_0004, out_seq=0; next record out_seq=1.
- N_HARTS=4, all harts push one packet in the same cycle, out_ready=1 -> grants 0,1,2,3 on consecutive cycles. Second burst with RR pointer at 0 gives the same order; start at pointer=2 gives 2,3,0,1.
- out_ready=0 for 5 cycles with hart 0 queued, then hart 0 FIFO fills and hart 3 pushes -> out_hart stays 0 and out_rec stays stable for all 5 cycles.
- DEPTH=4, hart2 pushes 6 packets with out_ready=0 -> drop_cnt[2]=2, ovf_sticky[2]=1. Then clr_stats=1 coincident with a 7th drop -> drop_cnt[2]=0.
- FIFO full and push with simultaneous pop on the same hart -> no drop. Count stays 0 and the 5th packet appears after the 4th.
- reset_n asserted mid-stream with 3 queued records -> out_valid=0 immediately (async), out_seq=0, FIFOs empty after release. DROP_W=4 with 20 drops -> drop_cnt=15.
